psram_responder: RTL
====================

Name: psram_responder

Overview:
- Synthesizable responder for the async multiplexed address/data PSRAM pin interface; it sits on the far end of the cram_* pins from the PSRAM controller.
- Used in benches and loopback builds: it decodes address, write and read phases from the pins and backs them with an internal word array.
- It drives read data onto cram_dq and flags protocol and timing violations.
- Pins are sampled on the same clock as the controller, so there are no synchronizers.

Parameters:
MEM_ADDR_WIDTH, 10, word-address bits of the backing array (2^N x 16); higher address bits alias.
BANK, 0, selects which chip enable this instance answers: 0 = cram_ce0_n, 1 = cram_ce1_n.
MIN_ADV_CYCLES, 1, minimum consecutive cycles cram_adv_n must be sampled low.
MIN_WE_CYCLES, 2, minimum cycles cram_we_n must be sampled low in the data phase.
READ_LATENCY, 1, cycles from cram_oe_n sampled low to cram_dq driven (range 1-15).

Ports:
clk  in  1  system clock; all pins sampled at posedge
reset_n  in  1  asynchronous active-low reset
cram_a  in  6  address bits [21:16]
cram_dq  inout  16  multiplexed address/data
cram_wait  out  1  always 0 (async mode)
cram_clk  in  1  ignored
cram_adv_n  in  1  address valid, active low
cram_cre  in  1  config register enable
cram_ce0_n  in  1  bank 0 chip enable
cram_ce1_n  in  1  bank 1 chip enable
cram_oe_n  in  1  output enable
cram_we_n  in  1  write enable
cram_ub_n  in  1  upper byte enable
cram_lb_n  in  1  lower byte enable
write_count  out  16  committed writes, wraps
read_count  out  16  completed reads, wraps
err_timing  out  1  sticky timing violation
err_protocol  out  1  sticky protocol violation

Behaviour:
- Reset (async): state IDLE, dq released (Z), counters 0, err flags 0, latched address/data 0. Array contents are not reset. Reset mid-transaction abandons it; a pending write is not committed.
- ce_n below means the chip enable selected by BANK. All decisions use the values registered at the posedge.
- IDLE: ce_n high ignores all pins. ce_n low with adv_n low: latch addr = {cram_a, cram_dq}, adv_cnt=1, go ADDR. ce_n low with adv_n high: stay IDLE, no effect.
- cram_cre high at transaction start: set err_protocol, go IGNORE until ce_n high; no array access, no count.
- ADDR: each cycle adv_n is low, re-latch the address (last wins) and increment adv_cnt (saturating at 15). On adv_n high: if adv_cnt < MIN_ADV_CYCLES set err_timing; go ACTIVE. ce_n high while in ADDR: set err_protocol, go IDLE.
- ACTIVE write path, each cycle with we_n low:
  - capture dq into wdata and ~ub_n/~lb_n into byte masks; set wr_pend; increment we_cnt (saturating at 15).
  - Cycles where dq still carries the address are overwritten by later samples; the last sample with we_n low wins.
- ACTIVE commit trigger: we_n sampled high, or ce_n sampled high, with wr_pend set.
  - Write the masked bytes of wdata to array[addr[MEM_ADDR_WIDTH-1:0]]; both masks clear means no byte changes, but the write is still counted.
  - Increment write_count, clear wr_pend.
  - If we_cnt < MIN_WE_CYCLES, set err_timing.
- ACTIVE read path:
  - oe_n low and we_n high: start lat_cnt.
  - After READ_LATENCY sampled-low cycles, the registered dq_oe goes 1 and dq drives the full word array[addr]; ub_n/lb_n do not mask reads.
  - The drive persists until the posedge where oe_n or ce_n is sampled high; dq_oe clears on that edge. The controller therefore still sees valid data on the edge it raises oe_n.
  - read_count increments once, on the edge dq_oe goes 1.
- oe_n and we_n both low in ACTIVE: set err_protocol; read suppressed (dq stays Z); write still captured.
- adv_n low again while in ACTIVE: commit any pending write, then treat as a new address phase (go ADDR).
- ce_n sampled high in ACTIVE or IGNORE: commit a pending write, release dq, go IDLE.
- Same-cycle read-after-write to the same address in back-to-back transactions returns the new data; the array write completes before the next ADDR.
- Counters wrap 0xFFFF -> 0x0000.

Test Plan:
- Write then read: controller-style write to addr 0x000123 data 0xBEEF, both bytes, BANK=0 -> write_count=1; then read of 0x000123 -> dq=0xBEEF driven READ_LATENCY cycles after oe_n low, read_count=1, no errors.
- Byte lanes: preload 0x1234 at 0x10; write 0xABCD with only ub_n low -> readback 0xAB34; write with both masks high -> data unchanged, write_count still increments.
- Bank select: BANK=1 instance, transaction on ce0_n only -> dq stays Z, counters stay 0; the same transaction on ce1_n is serviced.
- Timing violations: MIN_WE_CYCLES=3 with we_n low 2 cycles -> err_timing=1, write committed; MIN_ADV_CYCLES=2 with adv_n low 1 cycle -> err_timing=1.
- Protocol: cre=1 at transaction start -> err_protocol=1, array/counters unchanged; oe_n and we_n both low -> err_protocol=1, dq Z.
- Reset mid-read: assert reset_n low while dq is driven -> dq Z immediately (async), state IDLE, counters 0; the next write/read of 0x2A with data 0x5555 works normally.

Source files
------------

// File: rtl/psram_responder.sv
// psram_responder: far-end model of an async multiplexed-address PSRAM.
// Decodes address, write and read phases from the cram_* pins.
// Backs them with a word array, drives read data back onto cram_dq,
// and keeps sticky flags for timing and protocol violations.
module psram_responder #(
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int BANK           = 0,
   parameter int MIN_ADV_CYCLES = 1,
   parameter int MIN_WE_CYCLES  = 2,
   parameter int READ_LATENCY   = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  cram_a,
   inout  wire  [15:0] cram_dq,
   output logic        cram_wait,
   input  logic        cram_clk,
   input  logic        cram_adv_n,
   input  logic        cram_cre,
   input  logic        cram_ce0_n,
   input  logic        cram_ce1_n,
   input  logic        cram_oe_n,
   input  logic        cram_we_n,
   input  logic        cram_ub_n,
   input  logic        cram_lb_n,
   output logic [15:0] write_count,
   output logic [15:0] read_count,
   output logic        err_timing,
   output logic        err_protocol
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACTIVE,
      ST_IGNORE
   } state_t;

   localparam int          DEPTH   = 2 ** MEM_ADDR_WIDTH;
   localparam logic [3:0]  MIN_ADV = 4'(MIN_ADV_CYCLES);
   localparam logic [3:0]  MIN_WE  = 4'(MIN_WE_CYCLES);
   localparam logic [3:0]  RD_LAT  = 4'(READ_LATENCY);

   state_t       state_reg, state_next;
   logic [21:0]  addr_reg, addr_next;
   logic [15:0]  wdata_reg, wdata_next;
   logic         ub_reg, ub_next;
   logic         lb_reg, lb_next;
   logic         wr_pend_reg, wr_pend_next;
   logic [3:0]   adv_cnt_reg, adv_cnt_next;
   logic [3:0]   we_cnt_reg, we_cnt_next;
   logic [3:0]   lat_cnt_reg, lat_cnt_next;
   logic         dq_oe_reg, dq_oe_next;
   logic [15:0]  write_count_reg, write_count_next;
   logic [15:0]  read_count_reg, read_count_next;
   logic         err_timing_reg, err_timing_next;
   logic         err_protocol_reg, err_protocol_next;

   logic         ce_n;
   logic         commit;
   logic [3:0]   adv_inc, we_inc, lat_inc;
   logic [MEM_ADDR_WIDTH-1:0] mem_idx;

   logic [15:0]  mem [0:DEPTH-1];
   logic [15:0]  rd_word_reg;

   // Only one chip enable belongs to this instance.
   assign ce_n    = (BANK == 0) ? cram_ce0_n : cram_ce1_n;
   assign mem_idx = addr_reg[MEM_ADDR_WIDTH-1:0];

   // Saturating increments for the 4-bit phase counters.
   assign adv_inc = (adv_cnt_reg == 4'd15) ? 4'd15 : adv_cnt_reg + 4'd1;
   assign we_inc  = (we_cnt_reg  == 4'd15) ? 4'd15 : we_cnt_reg  + 4'd1;
   assign lat_inc = (lat_cnt_reg == 4'd15) ? 4'd15 : lat_cnt_reg + 4'd1;

   // Async mode: the wait pin is never used. cram_clk has no role here.
   assign cram_wait = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{cram_clk, addr_reg};

   assign cram_dq      = dq_oe_reg ? rd_word_reg : 16'hzzzz;
   assign write_count  = write_count_reg;
   assign read_count   = read_count_reg;
   assign err_timing   = err_timing_reg;
   assign err_protocol = err_protocol_reg;

   // State register and all control/status registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= ST_IDLE;
         addr_reg         <= '0;
         wdata_reg        <= '0;
         ub_reg           <= 1'b0;
         lb_reg           <= 1'b0;
         wr_pend_reg      <= 1'b0;
         adv_cnt_reg      <= '0;
         we_cnt_reg       <= '0;
         lat_cnt_reg      <= '0;
         dq_oe_reg        <= 1'b0;
         write_count_reg  <= '0;
         read_count_reg   <= '0;
         err_timing_reg   <= 1'b0;
         err_protocol_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         addr_reg         <= addr_next;
         wdata_reg        <= wdata_next;
         ub_reg           <= ub_next;
         lb_reg           <= lb_next;
         wr_pend_reg      <= wr_pend_next;
         adv_cnt_reg      <= adv_cnt_next;
         we_cnt_reg       <= we_cnt_next;
         lat_cnt_reg      <= lat_cnt_next;
         dq_oe_reg        <= dq_oe_next;
         write_count_reg  <= write_count_next;
         read_count_reg   <= read_count_next;
         err_timing_reg   <= err_timing_next;
         err_protocol_reg <= err_protocol_next;
      end
   end

   // Next-state logic: phase decoding, write capture/commit, read latency.
   always_comb begin
      state_next        = state_reg;
      addr_next         = addr_reg;
      wdata_next        = wdata_reg;
      ub_next           = ub_reg;
      lb_next           = lb_reg;
      wr_pend_next      = wr_pend_reg;
      adv_cnt_next      = adv_cnt_reg;
      we_cnt_next       = we_cnt_reg;
      lat_cnt_next      = lat_cnt_reg;
      dq_oe_next        = dq_oe_reg;
      write_count_next  = write_count_reg;
      read_count_next   = read_count_reg;
      err_timing_next   = err_timing_reg;
      err_protocol_next = err_protocol_reg;
      commit            = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (!ce_n && !cram_adv_n) begin
               if (cram_cre) begin
                  // Configuration accesses are not modelled.
                  err_protocol_next = 1'b1;
                  state_next        = ST_IGNORE;
               end else begin
                  addr_next    = {cram_a, cram_dq};
                  adv_cnt_next = 4'd1;
                  we_cnt_next  = 4'd0;
                  lat_cnt_next = 4'd0;
                  state_next   = ST_ADDR;
               end
            end
         end

         ST_ADDR: begin
            if (ce_n) begin
               err_protocol_next = 1'b1;
               state_next        = ST_IDLE;
            end else if (!cram_adv_n) begin
               addr_next    = {cram_a, cram_dq};
               adv_cnt_next = adv_inc;
            end else begin
               if (adv_cnt_reg < MIN_ADV) err_timing_next = 1'b1;
               state_next = ST_ACTIVE;
            end
         end

         ST_ACTIVE: begin
            if (ce_n) begin
               commit       = wr_pend_reg;
               dq_oe_next   = 1'b0;
               lat_cnt_next = 4'd0;
               state_next   = ST_IDLE;
            end else if (!cram_adv_n) begin
               // New address phase inside the same chip select.
               commit       = wr_pend_reg;
               dq_oe_next   = 1'b0;
               lat_cnt_next = 4'd0;
               addr_next    = {cram_a, cram_dq};
               adv_cnt_next = 4'd1;
               state_next   = ST_ADDR;
            end else if (!cram_we_n) begin
               // Last sample with we_n low wins.
               wdata_next   = cram_dq;
               ub_next      = ~cram_ub_n;
               lb_next      = ~cram_lb_n;
               wr_pend_next = 1'b1;
               we_cnt_next  = we_inc;
               dq_oe_next   = 1'b0;
               lat_cnt_next = 4'd0;
               if (!cram_oe_n) err_protocol_next = 1'b1;
            end else begin
               commit = wr_pend_reg;
               if (!cram_oe_n) begin
                  lat_cnt_next = lat_inc;
                  if (!dq_oe_reg && (lat_inc >= RD_LAT)) begin
                     dq_oe_next      = 1'b1;
                     read_count_next = read_count_reg + 16'd1;
                  end
               end else begin
                  lat_cnt_next = 4'd0;
                  dq_oe_next   = 1'b0;
               end
            end
         end

         ST_IGNORE: begin
            if (ce_n) state_next = ST_IDLE;
         end

         default: state_next = ST_IDLE;
      endcase

      if (commit) begin
         wr_pend_next     = 1'b0;
         we_cnt_next      = 4'd0;
         write_count_next = write_count_reg + 16'd1;
         if (we_cnt_reg < MIN_WE) err_timing_next = 1'b1;
      end
   end

   // Backing array: byte-lane writes, registered write-first read of the latched address.
   always_ff @(posedge clk) begin
      if (commit && ub_reg) mem[mem_idx][15:8] <= wdata_reg[15:8];
      if (commit && lb_reg) mem[mem_idx][7:0]  <= wdata_reg[7:0];
      rd_word_reg <= {(commit && ub_reg) ? wdata_reg[15:8] : mem[mem_idx][15:8],
                      (commit && lb_reg) ? wdata_reg[7:0]  : mem[mem_idx][7:0]};
   end

endmodule
